// File: rtl/decode_rf_unit.sv
// decode_rf_unit: decode-stage register file with operand forwarding,
// equality compare, immediate sign extension and branch-target adder.
// Optional feature: define RF_WRITE_BYPASS_EN to make a same-cycle write
// visible on the read ports (write-through). Without it, a read during
// the write cycle returns the stored value.
module decode_rf_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       instr_id32,
  input  logic [DATA_W-1:0] pc_plus4_id32,
  input  logic [DATA_W-1:0] alu_out_im32,
  input  logic              forward_rd1_id,
  input  logic              forward_rd2_id,
  input  logic              enable_wreg_iwb,
  input  logic [ADDR_W-1:0] dst_reg_addr_iwb5,
  input  logic [DATA_W-1:0] res_iwb32,
  output logic [DATA_W-1:0] rd1_o32,
  output logic [DATA_W-1:0] rd2_o32,
  output logic [DATA_W-1:0] fwd_rd1_o32,
  output logic [DATA_W-1:0] fwd_rd2_o32,
  output logic              zero_o,
  output logic [DATA_W-1:0] sign_imm_o32,
  output logic [DATA_W-1:0] pc_branch_o32
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0]        regs_q [NREG];
  logic [DATA_W-1:0]        regs_d [NREG];
  logic [ADDR_W-1:0]        rs_addr;
  logic [ADDR_W-1:0]        rt_addr;
  logic signed [DATA_W-1:0] sign_imm;
  logic                     unused_instr_bits;

  assign rs_addr           = instr_id32[21 +: ADDR_W];
  assign rt_addr           = instr_id32[16 +: ADDR_W];
  // Opcode field is decoded elsewhere; only the register/immediate fields are used here.
  assign unused_instr_bits = ^instr_id32[31:26];

  // Next register-file state: apply the write-back, keep r0 hard-wired to zero.
  always_comb begin
    regs_d = regs_q;
    if (enable_wreg_iwb && (dst_reg_addr_iwb5 != '0)) begin
      regs_d[dst_reg_addr_iwb5] = res_iwb32;
    end
    regs_d[0] = '0;
  end

  // Register storage; reset clears every entry immediately, without a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports, optionally bypassing the in-flight write.
  always_comb begin
    rd1_o32 = regs_q[rs_addr];
    rd2_o32 = regs_q[rt_addr];
`ifdef RF_WRITE_BYPASS_EN
    // Reset gates the bypass so the ports read zero throughout reset.
    if (rst_ni && enable_wreg_iwb && (dst_reg_addr_iwb5 == rs_addr) && (rs_addr != '0)) begin
      rd1_o32 = res_iwb32;
    end
    if (rst_ni && enable_wreg_iwb && (dst_reg_addr_iwb5 == rt_addr) && (rt_addr != '0)) begin
      rd2_o32 = res_iwb32;
    end
`endif
  end

  // Forwarding muxes, branch compare, immediate extension and branch target.
  always_comb begin
    fwd_rd1_o32   = forward_rd1_id ? alu_out_im32 : rd1_o32;
    fwd_rd2_o32   = forward_rd2_id ? alu_out_im32 : rd2_o32;
    zero_o        = (fwd_rd1_o32 == fwd_rd2_o32);
    sign_imm      = {{(DATA_W-16){instr_id32[15]}}, instr_id32[15:0]};
    sign_imm_o32  = $unsigned(sign_imm);
    // Word offset: carry out of the MSB is dropped, so targets wrap.
    pc_branch_o32 = pc_plus4_id32 + {sign_imm_o32[DATA_W-3:0], 2'b00};
  end

endmodule

// File: tb/tb_decode_rf_unit.sv
// tb_decode_rf_unit: directed bench for decode_rf_unit with a behavioural
// register-file model checked every cycle plus literal spot checks.
module tb_decode_rf_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] alu = '0;
  logic        fwd1 = 1'b0;
  logic        fwd2 = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  dst = '0;
  logic [31:0] res = '0;
  logic [31:0] rd1, rd2, frd1, frd2, simm, pcb;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  logic [31:0] mdl [32];

  decode_rf_unit #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .instr_id32        (instr),
    .pc_plus4_id32     (pc),
    .alu_out_im32      (alu),
    .forward_rd1_id    (fwd1),
    .forward_rd2_id    (fwd2),
    .enable_wreg_iwb   (we),
    .dst_reg_addr_iwb5 (dst),
    .res_iwb32         (res),
    .rd1_o32           (rd1),
    .rd2_o32           (rd2),
    .fwd_rd1_o32       (frd1),
    .fwd_rd2_o32       (frd2),
    .zero_o            (zero),
    .sign_imm_o32      (simm),
    .pc_branch_o32     (pcb)
  );

  always #5 clk = ~clk;

  // Reference register file: 32 words, r0 never written, cleared by reset.
  initial for (int i = 0; i < 32; i++) mdl[i] = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] <= '0;
    end else if (we && dst != 5'd0) begin
      mdl[dst] <= res;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input int addr);
    logic [31:0] v;
    if (addr == 0) return 32'd0;
    v = mdl[addr];
`ifdef RF_WRITE_BYPASS_EN
    if (rst_n && we && int'(dst) == addr) v = res;
`endif
    return v;
  endfunction

  // Every cycle, away from the active edge, check all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] e1, e2, f1, f2, si, pb;
      e1 = exp_read(int'(instr[25:21]));
      e2 = exp_read(int'(instr[20:16]));
      f1 = fwd1 ? alu : e1;
      f2 = fwd2 ? alu : e2;
      si = 32'($signed(instr[15:0]));
      pb = pc + si * 32'd4;
      chk("m_rd1", rd1, e1);
      chk("m_rd2", rd2, e2);
      chk("m_fwd1", frd1, f1);
      chk("m_fwd2", frd2, f2);
      chk("m_zero", {31'd0, zero}, {31'd0, f1 == f2});
      chk("m_simm", simm, si);
      chk("m_pcb", pcb, pb);
    end
  end

  function automatic logic [31:0] mk(input int rs, input int rt, input logic [15:0] imm);
    logic [4:0] a, b;
    a = 5'(rs);
    b = 5'(rt);
    return {6'd0, a, b, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int r, input logic [31:0] v);
    we = 1'b1; dst = 5'(r); res = v;
    step();
    we = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    // Writes attempted during reset are ignored; reads return zero.
    instr = mk(5, 5, 16'h0);
    we = 1'b1; dst = 5'd5; res = 32'hFF;
    step();
    #1 chk("rst_rd1", rd1, 32'h0);
    chk("rst_rd2", rd2, 32'h0);
    step();
    we = 1'b0;
    rst_n = 1'b1;
    #1 chk("rst_hold", rd1, 32'h0);

    // Reset clears immediately, without a clock edge.
    wr(5, 32'h1234);
    #1 chk("r5_wr", rd1, 32'h1234);
    #1 rst_n = 1'b0;
    #1 chk("async_rst", rd1, 32'h0);
    step();
    rst_n = 1'b1;

    // Write/read, and r0 stays zero.
    wr(8, 32'hDEADBEEF);
    wr(0, 32'hFFFFFFFF);
    instr = mk(8, 0, 16'h0);
    #1 chk("r8_rd1", rd1, 32'hDEADBEEF);
    chk("r0_rd2", rd2, 32'h0);
    instr = mk(8, 8, 16'h0);
    #1 chk("same_rd1", rd1, 32'hDEADBEEF);
    chk("same_rd2", rd2, 32'hDEADBEEF);
    step();

    // Reset during a write leaves the register cleared; writes resume after.
    wr(9, 32'h1111);
    instr = mk(9, 0, 16'h0);
    we = 1'b1; dst = 5'd9; res = 32'hAAAA;
    #2 rst_n = 1'b0;
    step();
    rst_n = 1'b1; we = 1'b0;
    #1 chk("midwr_rst", rd1, 32'h0);
    wr(9, 32'hBBBB);
    #1 chk("resume_wr", rd1, 32'hBBBB);

    // Forwarding and compare.
    wr(1, 32'd7);
    wr(2, 32'd9);
    instr = mk(1, 2, 16'h0);
    alu = 32'd9; fwd1 = 1'b1;
    #1 chk("fwd1_val", frd1, 32'd9);
    chk("fwd_zero1", {31'd0, zero}, 32'd1);
    fwd1 = 1'b0;
    #1 chk("nofwd_zero", {31'd0, zero}, 32'd0);
    chk("nofwd_val", frd1, 32'd7);
    alu = 32'd7; fwd2 = 1'b1;
    #1 chk("fwd2_val", frd2, 32'd7);
    chk("fwd_zero2", {31'd0, zero}, 32'd1);
    fwd2 = 1'b0; alu = '0;
    step();

    // Immediate extension and branch target, including wrap.
    pc = 32'h0000_0010; instr = mk(0, 0, 16'hFFFC);
    #1 chk("simm_neg", simm, 32'hFFFF_FFFC);
    chk("pcb_neg", pcb, 32'h0000_0000);
    instr = mk(0, 0, 16'h0003);
    #1 chk("simm_pos", simm, 32'h0000_0003);
    chk("pcb_pos", pcb, 32'h0000_001C);
    pc = 32'hFFFF_FFFC; instr = mk(0, 0, 16'h0001);
    #1 chk("pcb_wrap", pcb, 32'h0000_0000);
    step();

    // Same-cycle write and read.
    wr(3, 32'h11);
    instr = mk(3, 0, 16'h0);
    we = 1'b1; dst = 5'd3; res = 32'h55;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    chk("bypass_rd1", rd1, 32'h55);
`else
    chk("bypass_rd1", rd1, 32'h11);
`endif
    chk("bypass_rd2", rd2, 32'h0);
    step();
    we = 1'b0;
    #1 chk("after_wr", rd1, 32'h55);

    // Mixed traffic checked by the model each cycle.
    for (int k = 0; k < 40; k++) begin
      logic [31:0] r;
      we    = 1'($urandom_range(0, 1));
      dst   = 5'($urandom_range(0, 31));
      res   = $urandom;
      r     = $urandom;
      if (k % 2 == 0) r[25:21] = dst;
      if (k % 3 == 0) r[20:16] = r[25:21];
      instr = r;
      pc    = $urandom;
      alu   = (k % 4 == 0) ? mdl[r[20:16]] : $urandom;
      fwd1  = 1'($urandom_range(0, 1));
      fwd2  = 1'($urandom_range(0, 1));
      step();
    end
    we = 1'b0;
    step();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_rf_unit.md
DECODE_RF_UNIT -- requirements
Module: decode_rf_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register, operand and PC width.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width (2**ADDR_W registers).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port instr_id32, input, 32 bits: decode-stage instruction; rs=[25:21], rt=[20:16], imm=[15:0].
REQ-006 SHALL have port pc_plus4_id32, input, 32 bits: PC+4 of the instruction being decoded.
REQ-007 SHALL have port alu_out_im32, input, 32 bits: memory-stage ALU result used for forwarding.
REQ-008 SHALL have ports forward_rd1_id and forward_rd2_id, input, 1 bit each: select alu_out_im32 in place of rd1 / rd2.
REQ-009 SHALL have port enable_wreg_iwb, input, 1 bit: write-back write enable.
REQ-010 SHALL have port dst_reg_addr_iwb5, input, 5 bits: write-back destination register.
REQ-011 SHALL have port res_iwb32, input, 32 bits: write-back data.
REQ-012 SHALL have ports rd1_o32 and rd2_o32, output, 32 bits each: register-file read of rs and rt.
REQ-013 SHALL have ports fwd_rd1_o32 and fwd_rd2_o32, output, 32 bits each: post-forwarding operands.
REQ-014 SHALL have port zero_o, output, 1 bit: 1 when fwd_rd1_o32 == fwd_rd2_o32.
REQ-015 SHALL have port sign_imm_o32, output, 32 bits: instr_id32[15:0] sign-extended.
REQ-016 SHALL have port pc_branch_o32, output, 32 bits: branch target.

Function
REQ-017 SHALL contain 32 registers of 32 bits; register 0 SHALL read 0 always, and writes to it SHALL be ignored.
REQ-018 SHALL perform reads combinationally (zero latency) on rs and rt.
REQ-019 SHALL write res_iwb32 into dst_reg_addr_iwb5 on the rising edge of clk_i when enable_wreg_iwb=1 and rst_ni=1.
REQ-020 SHALL hold all registers when enable_wreg_iwb=0.
REQ-021 SHALL give fwd_rdN_o32 = forward_rdN_id ? alu_out_im32 : rdN_o32 (2:1 mux per operand).
REQ-022 SHALL compute zero_o combinationally from the forwarded operands only.
REQ-023 SHALL give sign_imm_o32 = {16{instr_id32[15]}, instr_id32[15:0]}.
REQ-024 SHALL give pc_branch_o32 = pc_plus4_id32 + (sign_imm_o32 << 2), modulo 2**32, with carry discarded and wrap-around permitted.
REQ-025 SHALL have no output registers; every output SHALL follow its inputs within the same cycle.
REQ-026 SHALL let rs and rt address the same register and return the same value on both ports.

Reset
REQ-027 SHALL clear all registers to 0 immediately while rst_ni=0, independent of clk_i.
REQ-028 SHALL ignore write enables while in reset; rd1_o32 and rd2_o32 SHALL read 0.
REQ-029 SHALL, if reset is asserted mid-write, leave the register cleared to 0 and not written.
REQ-030 SHALL resume writes on the first rising edge after rst_ni deasserts.

Configuration
REQ-031 SHALL, with macro RF_WRITE_BYPASS_EN defined, return res_iwb32 combinationally on a read port whenever enable_wreg_iwb=1 and dst_reg_addr_iwb5 equals that port's nonzero read address (write-through).
REQ-032 SHALL, without RF_WRITE_BYPASS_EN, return the stored (pre-write) value during the write cycle, with the new value visible the cycle after the edge.

Verification
REQ-033 SHALL cover reset: assert rst_ni=0 after writing r5=0x1234 -> rd1_o32=0 for rs=5 immediately, with no clock edge needed.
REQ-034 SHALL cover write/read: write r8=0xDEADBEEF, then rs=8, rt=0 -> rd1_o32=0xDEADBEEF, rd2_o32=0; write r0=0xFFFF_FFFF -> r0 still reads 0.
REQ-035 SHALL cover forwarding: r1=7, r2=9, alu_out_im32=9, forward_rd1_id=1 -> fwd_rd1_o32=9, zero_o=1; with forward_rd1_id=0 -> zero_o=0.
REQ-036 SHALL cover branch target: pc_plus4=0x0000_0010, imm=0xFFFC -> sign_imm_o32=0xFFFF_FFFC, pc_branch_o32=0x0000_0000; imm=0x0003 -> 0x0000_001C.
REQ-037 SHALL cover wrap: pc_plus4=0xFFFF_FFFC, imm=0x0001 -> pc_branch_o32=0x0000_0000.
REQ-038 SHALL cover bypass: same-cycle write r3=0x55 with rs=3 -> rd1_o32=0x55 with RF_WRITE_BYPASS_EN defined, old value without it.
